// File: rtl/unshuffle_reader.sv
// Raster-order readback of one 4-bank activation SRAM group holding a pixel-unshuffled image.
// One byte per pixel flows through a credit-limited 2-entry output FIFO with valid/ready.
module unshuffle_reader #(
    parameter int unsigned IMG_W        = 28,
    parameter int unsigned IMG_H        = 28,
    parameter int unsigned BW_PER_ACT   = 8,
    parameter int unsigned CH_NUM       = 4,
    parameter int unsigned ACT_PER_ADDR = 4,
    parameter int unsigned ADDR_W       = 6,
    localparam int unsigned WORD_W      = CH_NUM * ACT_PER_ADDR * BW_PER_ACT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  bank_sel,
    input  logic [WORD_W-1:0]     sram_rdata_a0,
    input  logic [WORD_W-1:0]     sram_rdata_a1,
    input  logic [WORD_W-1:0]     sram_rdata_a2,
    input  logic [WORD_W-1:0]     sram_rdata_a3,
    input  logic [WORD_W-1:0]     sram_rdata_b0,
    input  logic [WORD_W-1:0]     sram_rdata_b1,
    input  logic [WORD_W-1:0]     sram_rdata_b2,
    input  logic [WORD_W-1:0]     sram_rdata_b3,
    output logic [ADDR_W-1:0]     sram_raddr_a0,
    output logic [ADDR_W-1:0]     sram_raddr_a1,
    output logic [ADDR_W-1:0]     sram_raddr_a2,
    output logic [ADDR_W-1:0]     sram_raddr_a3,
    output logic [ADDR_W-1:0]     sram_raddr_b0,
    output logic [ADDR_W-1:0]     sram_raddr_b1,
    output logic [ADDR_W-1:0]     sram_raddr_b2,
    output logic [ADDR_W-1:0]     sram_raddr_b3,
    output logic [BW_PER_ACT-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int unsigned XY_W   = $clog2((IMG_W > IMG_H ? IMG_W : IMG_H) + 1);
    localparam int unsigned NBYTE  = CH_NUM * ACT_PER_ADDR;
    localparam int unsigned IDX_W  = $clog2(NBYTE);
    localparam int unsigned BSEL_W = $clog2(WORD_W);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state, state_nxt;
    logic                accept_c, issue_c, finish_c, last_pix_c, pop_c;
    logic [XY_W-1:0]     x_q, y_q;
    logic                grp_q;
    logic [ADDR_W-1:0]   raddr_a, raddr_b;
    logic [XY_W-1:0]     u, v, bu, bv;
    logic [1:0]          c_idx, a_idx, bank_idx;
    logic [IDX_W-1:0]    byte_idx;
    logic [ADDR_W-1:0]   addr;
    logic                v1_q, v2_q;
    logic [1:0]          bank1_q, bank2_q;
    logic [IDX_W-1:0]    idx1_q, idx2_q;
    logic [WORD_W-1:0]   word;
    logic [BSEL_W-1:0]   bsel;
    logic [BW_PER_ACT-1:0] rd_byte;
    logic                skid_valid;
    logic [BW_PER_ACT-1:0] skid_data;
    logic [2:0]          occupancy;

    // Everything issued but not yet handed to the consumer holds a credit.
    assign occupancy  = 3'(out_valid) + 3'(skid_valid) + 3'(v1_q) + 3'(v2_q);
    assign last_pix_c = (x_q == XY_W'(IMG_W - 1)) && (y_q == XY_W'(IMG_H - 1));
    assign pop_c      = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (issue_c && last_pix_c) state_nxt = DRAIN;
            DRAIN:   if (finish_c) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        accept_c = 1'b0;
        issue_c  = 1'b0;
        finish_c = 1'b0;
        unique case (state)
            IDLE:    accept_c = start;
            RUN:     issue_c  = (occupancy < 3'd2);
            DRAIN:   finish_c = (occupancy == 3'd0);
            default: ;
        endcase
    end

    // Pixel (x,y) -> bank, word address and byte lane in the unshuffled layout.
    always_comb begin
        u        = x_q >> 1;
        v        = y_q >> 1;
        bu       = u >> 1;
        bv       = v >> 1;
        c_idx    = {y_q[0], x_q[0]};
        a_idx    = {v[0], u[0]};
        bank_idx = {bv[0], bu[0]};
        addr     = ADDR_W'(32'(bv >> 1) * 32'd4 + 32'(bu >> 1));
        byte_idx = IDX_W'({c_idx, a_idx});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            grp_q   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            raddr_a <= '0;
            raddr_b <= '0;
        end else begin
            done <= finish_c;
            if (accept_c) begin
                x_q     <= '0;
                y_q     <= '0;
                grp_q   <= bank_sel;
                busy    <= 1'b1;
                raddr_a <= '0;
                raddr_b <= '0;
            end
            if (finish_c) busy <= 1'b0;
            if (issue_c) begin
                if (grp_q) raddr_b <= addr;
                else       raddr_a <= addr;
                if (x_q == XY_W'(IMG_W - 1)) begin
                    x_q <= '0;
                    y_q <= y_q + XY_W'(1);
                end else begin
                    x_q <= x_q + XY_W'(1);
                end
            end
        end
    end

    assign sram_raddr_a0 = raddr_a;
    assign sram_raddr_a1 = raddr_a;
    assign sram_raddr_a2 = raddr_a;
    assign sram_raddr_a3 = raddr_a;
    assign sram_raddr_b0 = raddr_b;
    assign sram_raddr_b1 = raddr_b;
    assign sram_raddr_b2 = raddr_b;
    assign sram_raddr_b3 = raddr_b;

    // Lane select follows the read: stage 1 aligns with raddr, stage 2 with rdata.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            bank1_q <= '0;
            bank2_q <= '0;
            idx1_q  <= '0;
            idx2_q  <= '0;
        end else begin
            v1_q    <= issue_c;
            v2_q    <= v1_q;
            bank2_q <= bank1_q;
            idx2_q  <= idx1_q;
            if (issue_c) begin
                bank1_q <= bank_idx;
                idx1_q  <= byte_idx;
            end
        end
    end

    always_comb begin
        word = '0;
        unique case (bank2_q)
            2'd0: word = grp_q ? sram_rdata_b0 : sram_rdata_a0;
            2'd1: word = grp_q ? sram_rdata_b1 : sram_rdata_a1;
            2'd2: word = grp_q ? sram_rdata_b2 : sram_rdata_a2;
            2'd3: word = grp_q ? sram_rdata_b3 : sram_rdata_a3;
            default: word = '0;
        endcase
        bsel    = BSEL_W'((NBYTE - 1 - 32'(idx2_q)) * BW_PER_ACT);
        rd_byte = word[bsel +: BW_PER_ACT];
    end

    // Output register is the FIFO head; the skid entry is the second slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
        end else if (!out_valid || pop_c) begin
            if (skid_valid) begin
                out_valid  <= 1'b1;
                out_data   <= skid_data;
                skid_valid <= v2_q;
                if (v2_q) skid_data <= rd_byte;
            end else begin
                out_valid <= v2_q;
                if (v2_q) out_data <= rd_byte;
            end
        end else if (v2_q) begin
            skid_valid <= 1'b1;
            skid_data  <= rd_byte;
        end
    end

endmodule

// File: tb/tb_unshuffle_reader.sv
// Directed bench for unshuffle_reader: SRAM models for both groups, raster-order stream checks.
module tb_unshuffle_reader;

    localparam int NPIX = 784;

    logic        clk = 1'b0;
    logic        rst_n, start, bank_sel, out_ready;
    logic [127:0] rdata_a [4];
    logic [127:0] rdata_b [4];
    logic [5:0]  raddr_a [4];
    logic [5:0]  raddr_b [4];
    logic [7:0]  out_data;
    logic        out_valid, busy, done;

    logic [127:0] mem_a [4][64];
    logic [127:0] mem_b [4][64];

    int checks = 0;
    int errors = 0;

    logic [7:0] got [$];
    int stall_err, done_cnt, timed_out;

    logic mon_en = 1'b0;
    logic mon_clr = 1'b0;
    logic mon_grp = 1'b0;
    int   addr_log [$];
    logic [5:0] mon_last;
    int   raddr_eq_err, raddr_idle_err;

    unshuffle_reader dut (
        .clk(clk), .rst_n(rst_n), .start(start), .bank_sel(bank_sel),
        .sram_rdata_a0(rdata_a[0]), .sram_rdata_a1(rdata_a[1]),
        .sram_rdata_a2(rdata_a[2]), .sram_rdata_a3(rdata_a[3]),
        .sram_rdata_b0(rdata_b[0]), .sram_rdata_b1(rdata_b[1]),
        .sram_rdata_b2(rdata_b[2]), .sram_rdata_b3(rdata_b[3]),
        .sram_raddr_a0(raddr_a[0]), .sram_raddr_a1(raddr_a[1]),
        .sram_raddr_a2(raddr_a[2]), .sram_raddr_a3(raddr_a[3]),
        .sram_raddr_b0(raddr_b[0]), .sram_raddr_b1(raddr_b[1]),
        .sram_raddr_b2(raddr_b[2]), .sram_raddr_b3(raddr_b[3]),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // SRAM with one-cycle read latency
    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            rdata_a[i] <= mem_a[i][raddr_a[i]];
            rdata_b[i] <= mem_b[i][raddr_b[i]];
        end
    end

    // Address monitor: logs every change of the active group's address, checks the idle group stays 0.
    always @(posedge clk) begin
        logic [5:0] act;
        #1;
        if (mon_clr) begin
            addr_log.delete();
            mon_last = 6'd0;
            raddr_eq_err = 0;
            raddr_idle_err = 0;
        end else if (mon_en) begin
            if (raddr_a[1] !== raddr_a[0] || raddr_a[2] !== raddr_a[0] || raddr_a[3] !== raddr_a[0] ||
                raddr_b[1] !== raddr_b[0] || raddr_b[2] !== raddr_b[0] || raddr_b[3] !== raddr_b[0])
                raddr_eq_err++;
            if ((mon_grp ? raddr_a[0] : raddr_b[0]) !== 6'd0) raddr_idle_err++;
            act = mon_grp ? raddr_b[0] : raddr_a[0];
            if (act !== mon_last) begin
                addr_log.push_back(int'(act));
                mon_last = act;
            end
        end
    end

    function automatic logic [7:0] exp_pix(input int kind, input int i);
        return (kind == 0) ? 8'(i) : 8'(i * 7 + 3);
    endfunction

    // Placement derived directly from pixel coordinates (block of 8 -> word, block of 4 -> bank).
    task automatic put_pixel(input bit grp, input int x, input int y, input logic [7:0] val);
        int bank, addr, idx;
        bank = ((y >> 2) & 1) * 2 + ((x >> 2) & 1);
        addr = (y >> 3) * 4 + (x >> 3);
        idx  = ((y & 1) * 2 + (x & 1)) * 4 + ((y >> 1) & 1) * 2 + ((x >> 1) & 1);
        if (grp) mem_b[bank][addr][(15 - idx) * 8 +: 8] = val;
        else     mem_a[bank][addr][(15 - idx) * 8 +: 8] = val;
    endtask

    task automatic clear_mem(input bit grp);
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 64; a++)
                if (grp) mem_b[b][a] = '0; else mem_a[b][a] = '0;
    endtask

    task automatic load_pattern(input bit grp, input int kind);
        clear_mem(grp);
        for (int y = 0; y < 28; y++)
            for (int x = 0; x < 28; x++)
                put_pixel(grp, x, y, exp_pix(kind, y * 28 + x));
    endtask

    function automatic int stream_mismatch(input int kind, output int first_bad);
        int n = 0;
        first_bad = -1;
        for (int i = 0; i < got.size() && i < NPIX; i++) begin
            if (got[i] !== exp_pix(kind, i)) begin
                if (first_bad < 0) first_bad = i;
                n++;
            end
        end
        return n;
    endfunction

    function automatic int log_mismatch();
        int exp_log [$];
        int last = 0, a, n = 0;
        for (int y = 0; y < 28; y++)
            for (int x = 0; x < 28; x++) begin
                a = (y >> 3) * 4 + (x >> 3);
                if (a != last) exp_log.push_back(a);
                last = a;
            end
        if (exp_log.size() != addr_log.size()) n++;
        for (int i = 0; i < exp_log.size() && i < addr_log.size(); i++)
            if (exp_log[i] != addr_log[i]) n++;
        return n;
    endfunction

    task automatic do_start(input bit grp);
        @(negedge clk);
        bank_sel = grp;
        start    = 1'b1;
        mon_grp  = grp;
        mon_clr  = 1'b1;
        mon_en   = 1'b0;
        @(negedge clk);
        start   = 1'b0;
        mon_clr = 1'b0;
        mon_en  = 1'b1;
    endtask

    // Consumes the stream from the current negedge; mode 0 ready=1, 1 random, 2 random + low burst.
    task automatic collect(input int stop_at, input int mode, input int start_at);
        int after_done;
        bit finished;
        logic pv, pr, r;
        logic [7:0] pd;
        got.delete();
        stall_err = 0; done_cnt = 0; timed_out = 0;
        pv = 1'b0; pr = 1'b1; pd = '0; after_done = 0; finished = 1'b0;
        for (int cyc = 0; cyc < 8000; cyc++) begin
            if (done === 1'b1) done_cnt++;
            if (pv && !pr && (out_valid !== 1'b1 || out_data !== pd)) stall_err++;
            case (mode)
                0:       r = 1'b1;
                1:       r = 1'($urandom_range(0, 1));
                default: r = (cyc >= 300 && cyc < 310) ? 1'b0 : 1'($urandom_range(0, 1));
            endcase
            start     = (start_at != 0 && cyc == start_at);
            bank_sel  = start ? !mon_grp : mon_grp;
            out_ready = r;
            if (out_valid === 1'b1 && r) got.push_back(out_data);
            pv = out_valid; pr = r; pd = out_data;
            if (stop_at != 0 && int'(got.size()) == stop_at) begin
                finished = 1'b1;
                break;
            end
            if (done_cnt != 0) after_done++;
            if (after_done > 3) begin
                finished = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!finished) timed_out = 1;
        mon_en = 1'b0;
    endtask

    task automatic test_reset;
        logic [5:0] ror;
        rst_n = 1'b0; start = 1'b0; bank_sel = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        ror = raddr_a[0] | raddr_a[1] | raddr_a[2] | raddr_a[3] |
              raddr_b[0] | raddr_b[1] | raddr_b[2] | raddr_b[3];
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'd0) begin
            errors++; $display("FAIL reset_out: valid=%b data=%0d expected 0/0", out_valid, out_data);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL reset_status: busy=%b done=%b expected 0/0", busy, done);
        end
        checks++;
        if (ror !== 6'd0) begin
            errors++; $display("FAIL reset_raddr: or=%0d expected 0", ror);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++; $display("FAIL idle_after_reset: busy=%b valid=%b expected 0/0", busy, out_valid);
        end
    endtask

    task automatic test_stream_a;
        int nbad, fb;
        load_pattern(1'b0, 0);
        out_ready = 1'b1;
        do_start(1'b0);
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL start_accept: busy=%b valid=%b expected 1/0", busy, out_valid);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL latency_early: valid=%b after E2 expected 0", out_valid);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'd0) begin
            errors++; $display("FAIL latency_first: valid=%b data=%0d after E3 expected 1/0", out_valid, out_data);
        end
        collect(0, 0, 0);
        checks++;
        if (timed_out != 0 || int'(got.size()) != NPIX) begin
            errors++; $display("FAIL stream_a_count: got %0d pixels (timeout=%0d) expected %0d", got.size(), timed_out, NPIX);
        end
        nbad = stream_mismatch(0, fb);
        checks++;
        if (nbad != 0) begin
            errors++; $display("FAIL stream_a_data: %0d bad pixels, first at %0d expected 0 bad", nbad, fb);
        end
        checks++;
        if (done_cnt != 1 || busy !== 1'b0) begin
            errors++; $display("FAIL stream_a_done: done pulses=%0d busy=%b expected 1/0", done_cnt, busy);
        end
        nbad = log_mismatch();
        checks++;
        if (nbad != 0 || raddr_eq_err != 0 || raddr_idle_err != 0) begin
            errors++; $display("FAIL stream_a_raddr: log_diff=%0d eq_err=%0d idle_err=%0d expected 0/0/0", nbad, raddr_eq_err, raddr_idle_err);
        end
    endtask

    task automatic test_mapping;
        int nz;
        clear_mem(1'b0);
        mem_a[0][0][71:64]  = 8'hA5;   // pixel (3,2)
        mem_a[0][15][7:0]   = 8'h5A;   // pixel (27,27)
        mem_a[0][0][95:88]  = 8'h3C;   // pixel (1,0)
        do_start(1'b0);
        collect(0, 0, 0);
        nz = 0;
        foreach (got[i]) if (got[i] !== 8'd0) nz++;
        checks++;
        if (int'(got.size()) != NPIX || got[59] !== 8'hA5) begin
            errors++; $display("FAIL map_3_2: size=%0d data=%0h expected %0d/a5", got.size(), got[59], NPIX);
        end
        checks++;
        if (int'(got.size()) != NPIX || got[783] !== 8'h5A) begin
            errors++; $display("FAIL map_27_27: data=%0h expected 5a", got[783]);
        end
        checks++;
        if (got[1] !== 8'h3C || nz != 3) begin
            errors++; $display("FAIL map_1_0: data=%0h nonzero=%0d expected 3c/3", got[1], nz);
        end
    endtask

    task automatic test_backpressure;
        int nbad, fb;
        load_pattern(1'b0, 0);
        do_start(1'b0);
        collect(0, 2, 0);
        nbad = stream_mismatch(0, fb);
        checks++;
        if (timed_out != 0 || int'(got.size()) != NPIX || nbad != 0) begin
            errors++; $display("FAIL bp_stream: size=%0d bad=%0d first=%0d expected %0d/0", got.size(), nbad, fb, NPIX);
        end
        checks++;
        if (stall_err != 0 || done_cnt != 1) begin
            errors++; $display("FAIL bp_stall: stall_err=%0d done=%0d expected 0/1", stall_err, done_cnt);
        end
    endtask

    task automatic test_bank_b;
        int nbad, fb, lbad;
        load_pattern(1'b1, 1);
        do_start(1'b1);
        collect(0, 1, 0);
        nbad = stream_mismatch(1, fb);
        checks++;
        if (timed_out != 0 || int'(got.size()) != NPIX || nbad != 0) begin
            errors++; $display("FAIL bank_b_stream: size=%0d bad=%0d first=%0d expected %0d/0", got.size(), nbad, fb, NPIX);
        end
        lbad = log_mismatch();
        checks++;
        if (raddr_idle_err != 0 || lbad != 0 || raddr_eq_err != 0) begin
            errors++; $display("FAIL bank_b_raddr: a_nonzero=%0d log_diff=%0d eq_err=%0d expected 0/0/0", raddr_idle_err, lbad, raddr_eq_err);
        end
    endtask

    task automatic test_start_and_reset;
        int nbad, fb;
        logic [5:0] ror;
        load_pattern(1'b0, 0);
        do_start(1'b0);
        collect(0, 0, 100);
        nbad = stream_mismatch(0, fb);
        checks++;
        if (timed_out != 0 || int'(got.size()) != NPIX || nbad != 0 || done_cnt != 1) begin
            errors++; $display("FAIL start_ignored: size=%0d bad=%0d done=%0d expected %0d/0/1", got.size(), nbad, done_cnt, NPIX);
        end
        do_start(1'b0);
        collect(300, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        ror = raddr_a[0] | raddr_a[1] | raddr_a[2] | raddr_a[3] |
              raddr_b[0] | raddr_b[1] | raddr_b[2] | raddr_b[3];
        checks++;
        if (out_valid !== 1'b0 || out_data !== 8'd0 || busy !== 1'b0 || done !== 1'b0 || ror !== 6'd0) begin
            errors++; $display("FAIL midrun_reset: valid=%b data=%0d busy=%b done=%b raddr=%0d expected all 0", out_valid, out_data, busy, done, ror);
        end
        rst_n = 1'b1;
        do_start(1'b0);
        collect(0, 0, 0);
        nbad = stream_mismatch(0, fb);
        checks++;
        if (timed_out != 0 || int'(got.size()) != NPIX || nbad != 0) begin
            errors++; $display("FAIL restart_stream: size=%0d bad=%0d first=%0d expected %0d/0", got.size(), nbad, fb, NPIX);
        end
    endtask

    task automatic test_ready_low;
        int nbad, fb, unstable;
        load_pattern(1'b1, 1);
        out_ready = 1'b0;
        do_start(1'b1);
        unstable = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i >= 4 && (out_valid !== 1'b1 || out_data !== 8'd3)) unstable++;
        end
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'd3 || unstable != 0 || busy !== 1'b1) begin
            errors++; $display("FAIL ready_low_hold: valid=%b data=%0d unstable=%0d busy=%b expected 1/3/0/1", out_valid, out_data, unstable, busy);
        end
        collect(0, 0, 0);
        nbad = stream_mismatch(1, fb);
        checks++;
        if (timed_out != 0 || int'(got.size()) != NPIX || nbad != 0 || done_cnt != 1) begin
            errors++; $display("FAIL ready_low_stream: size=%0d bad=%0d first=%0d done=%0d expected %0d/0/1", got.size(), nbad, fb, done_cnt, NPIX);
        end
    endtask

    initial begin
        clear_mem(1'b0);
        clear_mem(1'b1);
        test_reset();
        test_stream_a();
        test_mapping();
        test_backpressure();
        test_bank_b();
        test_start_and_reset();
        test_ready_low();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
